axi_pim_loader: RTL and testbench
=================================

// Module: axi_pim_loader
// PURPOSE
//  AXI4 write master that sits directly upstream of the AXI4 PIM RAM slave.
//  - Takes one load command (byte base address + word count) and a stream of weight words.
//  - Splits the load into INCR write bursts of at most MAX_BURST_LEN beats and drives them into the slave port.
//  - Reports completion and any non-OKAY write response.
//  - One burst outstanding at a time (AW -> W -> B), matching the slave's single-burst write FSM.
// PARAMETERS
//  DATA_WIDTH     32            AXI data width, bits; equals PIM word width
//  ADDR_WIDTH     8             AXI byte address width
//  STRB_WIDTH     DATA_WIDTH/8  wstrb width
//  ID_WIDTH       8             AXI ID width
//  AWID_VALUE     0             constant ID driven on awid
//  MAX_BURST_LEN  16            max beats per burst, 1..256, power of two
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active-high
//  cmd_addr       in   ADDR_WIDTH  byte base address; low log2(STRB_WIDTH) bits ignored (forced 0)
//  cmd_len        in   8           word count minus 1 (0 => 1 word, 255 => 256 words)
//  cmd_valid      in   1           command valid
//  cmd_ready      out  1           command accepted when cmd_valid && cmd_ready
//  s_axis_tdata   in   DATA_WIDTH  weight word stream
//  s_axis_tvalid  in   1           stream valid
//  s_axis_tready  out  1           stream ready
//  m_axi_aw*      out  -           awid,awaddr,awlen[7:0],awsize[2:0],awburst[1:0],awlock,awcache[3:0],awprot[2:0],awvalid
//  m_axi_awready  in   1           address ready
//  m_axi_w*       out  -           wdata,wstrb,wlast,wvalid
//  m_axi_wready   in   1           write-data ready
//  m_axi_b*       in   -           bid,bresp[1:0],bvalid;  m_axi_bready out 1
//  busy           out  1           high from command accept until done
//  done           out  1           one-cycle pulse after the final B response
//  error          out  1           sticky: any bresp!=OKAY in the current load; cleared on next cmd accept
// BEHAVIOUR
//  Reset: awvalid=wvalid=bready=0, cmd_ready=0, s_axis_tready=0, busy=done=error=0, state=IDLE.
//    cmd_ready rises the first cycle after rst deasserts.
//  Constant AXI fields:
//    awsize=log2(STRB_WIDTH); awburst=2'b01 (INCR); awlock=0; awcache=4'b0011; awprot=0.
//    wstrb all ones; awid=AWID_VALUE.
//  Counters:
//    addr_reg (ADDR_WIDTH bits); remaining words rem_reg (9 bits, = cmd_len+1 at accept);
//    beat counter beat_reg (8 bits).
//  Burst length: beats = min(rem_reg, MAX_BURST_LEN); awlen = beats-1.
//  States:
//    IDLE: cmd_ready=1. On accept, latch addr/len, clear error, busy=1 -> AW.
//    AW:   awvalid=1 with registered awaddr/awlen. On awready -> W, beat_reg=awlen.
//    W:    Pass-through, no buffering:
//            wvalid = s_axis_tvalid;  s_axis_tready = m_axi_wready;  wdata = tdata.
//            wlast = (beat_reg==0).
//          Each handshake: beat_reg--, rem_reg--, addr_reg += STRB_WIDTH.
//          Handshake with wlast -> B.
//    B:    bready=1. On bvalid: error |= (bresp!=2'b00).
//            rem_reg!=0 -> AW.
//            else -> DONE.
//    DONE: done=1 for exactly one cycle, busy=0 -> IDLE; cmd_ready=1 the following cycle.
//  Latency:
//    awvalid is high the cycle after cmd accept.
//    wvalid may assert the cycle after the AW handshake.
//  Wrap: addr_reg wraps modulo 2**ADDR_WIDTH, same as the slave incrementer; no 4KB split needed.
//  The stream is never read outside state W; excess stream words stay pending.
//  Commands presented while busy are not accepted (cmd_ready=0).
//  rst mid-burst aborts immediately to the reset values above; the partial burst is abandoned.
//  The slave is reset by the same rst.
//  Error response: the load continues to completion; error is flagged only.
// STRUCTURE
//  Shared package axi_pim_pkg:
//    AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00, CACHE_MODIFIABLE=4'b0011.
//    Loader state encoding (IDLE/AW/W/B/DONE, 3 bits).
//  One natural sub-module: axi_pim_burst_calc.
//    Combinational min(rem, MAX_BURST_LEN)-1 -> awlen, plus next-address add.
//    Everything else stays in a single FSM.
// TESTING (bench connects DUT to the AXI PIM RAM, DATA_WIDTH=32, ADDR_WIDTH=8)
//  1. cmd_addr=0x00, cmd_len=3, stream 0x11,0x22,0x33,0x44
//       -> one burst awlen=3; RAM words 0..3 hold values; done pulse, error=0.
//  2. cmd_addr=0x10, cmd_len=39
//       -> bursts awlen=15,15,7 at awaddr 0x10,0x50,0x90; done once after third B.
//  3. Stream tvalid toggling 1/0 every cycle, plus bready-side slave stall
//       -> no beat lost or duplicated; wlast only on beat 16 of each full burst.
//  4. cmd_addr=0xF8, cmd_len=3
//       -> words land at byte addresses 0xF8,0xFC,0x00,0x04 (wrap).
//  5. Force bresp=2'b10 on first of two bursts
//       -> load completes, error=1 until next cmd accept, then error=0.
//  6. Assert rst during W beat 5 of 16
//       -> next cycle all valids=0, busy=0; new cmd with cmd_len=0 completes normally.

Source files
------------

// File: rtl/axi_pim_pkg.sv
// rtl/axi_pim_pkg.sv - shared AXI constants and loader state encoding
package axi_pim_pkg;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } loader_state_e;

endpackage

// File: rtl/axi_pim_burst_calc.sv
// rtl/axi_pim_burst_calc.sv - burst length from remaining words, next beat address
module axi_pim_burst_calc #(
  parameter int ADDR_WIDTH    = 8,
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [8:0]            rem_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [7:0]            awlen_o,
  output logic [ADDR_WIDTH-1:0] addr_next_o
);

  localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST_LEN);

  logic [8:0] beats;
  logic [8:0] beats_m1;

  always_comb begin
    beats    = (rem_i > MAX_BEATS) ? MAX_BEATS : rem_i;
    beats_m1 = beats - 9'd1;
  end

  assign awlen_o     = beats_m1[7:0];
  // Wraps modulo 2**ADDR_WIDTH, matching the slave's own incrementer.
  assign addr_next_o = addr_i + ADDR_WIDTH'(STRB_WIDTH);

endmodule

// File: rtl/axi_pim_loader.sv
// rtl/axi_pim_loader.sv - AXI4 write master that streams a weight load into the PIM RAM
module axi_pim_loader
  import axi_pim_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AWID_VALUE    = 0,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            rem_q, rem_d;
  logic [7:0]            beat_q, beat_d;
  logic                  error_q, error_d;

  logic [7:0]            burst_len;
  logic [ADDR_WIDTH-1:0] addr_next;

  axi_pim_burst_calc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .STRB_WIDTH   (STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_calc (
    .rem_i      (rem_q),
    .addr_i     (addr_q),
    .awlen_o    (burst_len),
    .addr_next_o(addr_next)
  );

  assign m_axi_awid    = ID_WIDTH'(AWID_VALUE);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = burst_len;
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_MODIFIABLE;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign error         = error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    beat_d        = beat_q;
    error_d       = error_q;
    cmd_ready     = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while in reset so the first ready appears after release.
        cmd_ready = !rst;
        if (cmd_valid) begin
          addr_d  = cmd_addr & ADDR_MASK;
          rem_d   = {1'b0, cmd_len} + 9'd1;
          error_d = 1'b0;
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        busy          = 1'b1;
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          beat_d  = burst_len;
          state_d = ST_W;
        end
      end
      ST_W: begin
        // Stream passes straight through; no local buffering of beats.
        busy          = 1'b1;
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        m_axi_wlast   = (beat_q == 8'd0);
        if (s_axis_tvalid && m_axi_wready) begin
          beat_d = beat_q - 8'd1;
          rem_d  = rem_q - 9'd1;
          addr_d = addr_next;
          if (beat_q == 8'd0) state_d = ST_B;
        end
      end
      ST_B: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) error_d = 1'b1;
          state_d = (rem_q != 9'd0) ? ST_AW : ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_pim_loader.sv
// tb/tb_axi_pim_loader.sv - directed bench for axi_pim_loader against a behavioural PIM RAM slave
module tb_axi_pim_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axi_awid;
  logic [7:0]  m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  // Slave model state, written only by the slave process.
  logic [31:0] mem [0:63];
  logic [7:0]  aw_addr_log [0:63];
  logic [7:0]  aw_len_log [0:63];
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, wlast_err = 0;
  int          stream_rd = 0;
  logic [7:0]  wr_addr = '0;
  int          beats_left = 0;
  logic        b_pending = 1'b0;
  int          b_wait = 0;
  logic        phase = 1'b0;
  int          wr_ph = 0;

  // Bench controls, written only by the initial block.
  logic [31:0] stream_buf [0:1023];
  int          stream_wr = 0;
  logic        stall_en = 1'b0;
  logic        toggle_en = 1'b0;
  logic        err_en = 1'b0;
  int          err_b_idx = 0;

  axi_pim_loader dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Slave + stream source: observe handshakes at posedge, drive new inputs at negedge.
  always begin
    @(posedge clk);
    if (rst) begin
      b_pending  = 1'b0;
      beats_left = 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_log[aw_cnt] = m_axi_awaddr;
        aw_len_log[aw_cnt]  = m_axi_awlen;
        aw_cnt++;
        wr_addr    = m_axi_awaddr;
        beats_left = int'(m_axi_awlen);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        mem[wr_addr[7:2]] = m_axi_wdata;
        if (m_axi_wlast !== (beats_left == 0)) wlast_err++;
        w_cnt++;
        wr_addr = wr_addr + 8'd4;
        beats_left--;
        if (m_axi_wlast) begin
          b_pending = 1'b1;
          b_wait    = stall_en ? 3 : 0;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending = 1'b0;
        b_cnt++;
      end
      if (s_axis_tvalid && s_axis_tready) stream_rd++;
      if (done) done_cnt++;
    end
    @(negedge clk);
    phase = ~phase;
    wr_ph = (wr_ph + 1) % 3;
    s_axis_tvalid = (stream_rd < stream_wr) && (!toggle_en || phase);
    s_axis_tdata  = (stream_rd < stream_wr) ? stream_buf[stream_rd] : 32'h0;
    m_axi_awready = stall_en ? phase : 1'b1;
    m_axi_wready  = stall_en ? (wr_ph != 0) : 1'b1;
    if (b_pending && b_wait > 0) begin
      b_wait--;
      m_axi_bvalid = 1'b0;
    end else begin
      m_axi_bvalid = b_pending && !rst;
    end
    m_axi_bresp = (err_en && b_cnt == err_b_idx) ? 2'b10 : 2'b00;
  end

  task automatic push_word(input logic [31:0] d);
    stream_buf[stream_wr] = d;
    stream_wr++;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
    int n;
    n = 0;
    @(negedge clk);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checks++;
    if (n >= 50 || m_axi_awvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_latency waited=%0d awvalid=%b busy=%b expected awvalid=1 busy=1", n, m_axi_awvalid, busy);
    end
  endtask

  task automatic wait_done(input string name, input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - base != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done done_pulses=%0d busy=%b expected 1 pulse, busy=0", name, done_cnt - base, busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, cmd_ready, s_axis_tready, busy, done, error} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=00000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, cmd_ready, s_axis_tready, busy, done, error});
    end
    checks++;
    if ({m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awlock, m_axi_awprot, m_axi_wstrb, m_axi_awid}
        !== {3'd2, 2'b01, 4'b0011, 1'b0, 3'b000, 4'hF, 8'h00}) begin
      failures++;
      $display("FAIL const_fields size=%0d burst=%b cache=%b lock=%b prot=%b strb=%h id=%h expected 2/01/0011/0/000/f/00",
               m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awlock, m_axi_awprot, m_axi_wstrb, m_axi_awid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single;
    int ab, db;
    logic [31:0] exp [0:3];
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
    for (int i = 0; i < 4; i++) push_word(exp[i]);
    ab = aw_cnt; db = done_cnt;
    send_cmd(8'h00, 8'd3);
    wait_done("single", db);
    checks++;
    if (aw_cnt - ab != 1 || aw_len_log[ab] !== 8'd3 || aw_addr_log[ab] !== 8'h00) begin
      failures++;
      $display("FAIL single_aw bursts=%0d awlen=%0d awaddr=%h expected 1/3/00", aw_cnt - ab, aw_len_log[ab], aw_addr_log[ab]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[i] !== exp[i]) begin
        failures++;
        $display("FAIL single_mem[%0d] got=%h expected=%h", i, mem[i], exp[i]);
      end
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL single_error got=%b expected 0", error);
    end
  endtask

  task automatic test_multi;
    int ab, db, bad;
    logic [7:0] exp_addr [0:2];
    logic [7:0] exp_len [0:2];
    exp_addr[0] = 8'h10; exp_addr[1] = 8'h50; exp_addr[2] = 8'h90;
    exp_len[0] = 8'd15; exp_len[1] = 8'd15; exp_len[2] = 8'd7;
    for (int i = 0; i < 40; i++) push_word(32'h1000 + 32'(i));
    ab = aw_cnt; db = done_cnt;
    send_cmd(8'h10, 8'd39);
    wait_done("multi", db);
    checks++;
    if (aw_cnt - ab != 3) begin
      failures++;
      $display("FAIL multi_burst_count got=%0d expected 3", aw_cnt - ab);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (aw_addr_log[ab + k] !== exp_addr[k] || aw_len_log[ab + k] !== exp_len[k]) begin
        failures++;
        $display("FAIL multi_aw[%0d] awaddr=%h awlen=%0d expected %h/%0d", k, aw_addr_log[ab + k], aw_len_log[ab + k], exp_addr[k], exp_len[k]);
      end
    end
    bad = 0;
    for (int i = 0; i < 40; i++) if (mem[4 + i] !== 32'h1000 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL multi_mem wrong_words=%0d expected 0", bad);
    end
  endtask

  task automatic test_stall;
    int ab, db, wb, eb, bad;
    for (int i = 0; i < 32; i++) push_word(32'h3000 + 32'(i));
    stall_en = 1'b1; toggle_en = 1'b1;
    ab = aw_cnt; db = done_cnt; wb = w_cnt; eb = wlast_err;
    send_cmd(8'h20, 8'd31);
    wait_done("stall", db);
    stall_en = 1'b0; toggle_en = 1'b0;
    checks++;
    if (w_cnt - wb != 32 || wlast_err - eb != 0) begin
      failures++;
      $display("FAIL stall_beats beats=%0d wlast_errors=%0d expected 32/0", w_cnt - wb, wlast_err - eb);
    end
    checks++;
    if (aw_cnt - ab != 2 || aw_addr_log[ab + 1] !== 8'h60 || aw_len_log[ab + 1] !== 8'd15) begin
      failures++;
      $display("FAIL stall_aw bursts=%0d second_addr=%h second_len=%0d expected 2/60/15", aw_cnt - ab, aw_addr_log[ab + 1], aw_len_log[ab + 1]);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[8 + i] !== 32'h3000 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_mem wrong_words=%0d expected 0", bad);
    end
  endtask

  task automatic test_wrap;
    int ab, db;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    ab = aw_cnt; db = done_cnt;
    send_cmd(8'hF8, 8'd3);
    wait_done("wrap", db);
    checks++;
    if (aw_addr_log[ab] !== 8'hF8 || aw_len_log[ab] !== 8'd3) begin
      failures++;
      $display("FAIL wrap_aw awaddr=%h awlen=%0d expected f8/3", aw_addr_log[ab], aw_len_log[ab]);
    end
    checks++;
    if ({mem[62], mem[63], mem[0], mem[1]} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
      failures++;
      $display("FAIL wrap_mem got=%h %h %h %h expected a0 a1 a2 a3", mem[62], mem[63], mem[0], mem[1]);
    end
  endtask

  task automatic test_error;
    int db;
    for (int i = 0; i < 32; i++) push_word(32'h5000 + 32'(i));
    err_b_idx = b_cnt;
    err_en = 1'b1;
    db = done_cnt;
    send_cmd(8'h40, 8'd31);
    wait_done("error", db);
    err_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (error !== 1'b1 || mem[16 + 31] !== 32'h5000 + 32'd31) begin
      failures++;
      $display("FAIL error_sticky error=%b last_word=%h expected 1/0000501f", error, mem[47]);
    end
    push_word(32'h77);
    db = done_cnt;
    send_cmd(8'h00, 8'd0);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL error_clear error=%b expected 0", error);
    end
    wait_done("error_next", db);
    checks++;
    if (error !== 1'b0 || mem[0] !== 32'h77) begin
      failures++;
      $display("FAIL error_next error=%b mem0=%h expected 0/00000077", error, mem[0]);
    end
  endtask

  task automatic test_reset_mid;
    int wb, n, ab, db;
    for (int i = 0; i < 16; i++) push_word(32'h6000 + 32'(i));
    wb = w_cnt;
    send_cmd(8'h40, 8'd15);
    n = 0;
    while (w_cnt - wb < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL reset_mid_reach beats=%0d expected 4", w_cnt - wb);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, s_axis_tready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b expected=000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, s_axis_tready});
    end
    #1;
    stream_wr = stream_rd;
    @(negedge clk);
    rst = 1'b0;
    push_word(32'hBEEF);
    ab = aw_cnt; db = done_cnt;
    send_cmd(8'h80, 8'd0);
    wait_done("reset_mid_new", db);
    checks++;
    if (aw_len_log[ab] !== 8'd0 || aw_addr_log[ab] !== 8'h80 || mem[32] !== 32'hBEEF) begin
      failures++;
      $display("FAIL reset_mid_new awlen=%0d awaddr=%h mem=%h expected 0/80/0000beef", aw_len_log[ab], aw_addr_log[ab], mem[32]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_wrap();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
